// File: rtl/cc_frame_driver.sv
// cc_frame_driver: buffers one 50-word CC game frame and replays it into CC.
// Optional protocol checker is built when CC_FEED_CHECK_EN is defined.
module cc_frame_driver #(
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld_valid,
   output logic       ld_ready,
   input  logic [7:0] ld_data,
   output logic       in_valid_1,
   output logic [2:0] in_color,
   output logic [5:0] in_starting_pos,
   output logic       in_stripe,
   output logic       in_valid_2,
   output logic [1:0] in_action,
   input  logic       cc_out_valid,
   input  logic [6:0] cc_out_score,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [6:0] res_score,
   output logic       res_timeout,
   output logic       err_proto
);

   typedef enum logic [2:0] {
      S_LOAD, S_FEED1, S_GAP, S_FEED2, S_WAIT, S_DONE
   } state_t;

   localparam logic [9:0] LP_GAP_LAST = 10'(GAP_CYCLES - 1);
   localparam logic [9:0] LP_TO_LAST  = 10'(TIMEOUT - 1);

   state_t     r_state, w_state_nxt;
   logic [9:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_buf [0:49];

   logic       w_ld_acc, w_cc_hit, w_to_hit;
   logic [5:0] w_fidx, w_sidx, w_aidx;

   logic       r_ld_ready, w_ld_ready;
   logic       r_in_valid_1, w_in_valid_1;
   logic [2:0] r_in_color, w_in_color;
   logic [5:0] r_in_pos, w_in_pos;
   logic       r_in_stripe, w_in_stripe;
   logic       r_in_valid_2, w_in_valid_2;
   logic [1:0] r_in_action, w_in_action;
   logic       r_res_valid, w_res_valid;
   logic [6:0] r_res_score, w_res_score;
   logic       r_res_timeout, w_res_timeout;

   assign w_ld_acc = (r_state == S_LOAD) & ld_valid & r_ld_ready;
   assign w_cc_hit = (r_state == S_WAIT) & cc_out_valid;
   assign w_to_hit = (r_state == S_WAIT) & ~cc_out_valid
                   & (r_cnt == LP_TO_LAST);

   // state and phase counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_LOAD;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // next-state and counter logic; counter restarts on every state change
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 10'd1;
      unique case (r_state)
         S_LOAD: begin
            w_cnt_nxt = r_cnt;
            if (w_ld_acc) begin
               if (r_cnt == 10'd49) begin
                  w_state_nxt = S_FEED1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 10'd1;
               end
            end
         end
         S_FEED1: begin
            if (r_cnt == 10'd35) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            if (r_cnt == LP_GAP_LAST) begin
               w_state_nxt = S_FEED2;
               w_cnt_nxt   = '0;
            end
         end
         S_FEED2: begin
            if (r_cnt == 10'd9) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (w_cc_hit || w_to_hit) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end
         end
         S_DONE: begin
            w_cnt_nxt = '0;
            if (r_res_valid && res_ready) begin
               w_state_nxt = S_LOAD;
            end
         end
         default: begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_fidx = w_cnt_nxt[5:0];
   assign w_sidx = 6'd36 + w_fidx;
   assign w_aidx = 6'd40 + w_fidx;

   // next values of the registered outputs, derived from the upcoming state
   always_comb begin
      w_ld_ready    = (w_state_nxt == S_LOAD);
      w_res_valid   = (w_state_nxt == S_DONE);
      w_in_valid_1  = 1'b0;
      w_in_color    = '0;
      w_in_pos      = '0;
      w_in_stripe   = 1'b0;
      w_in_valid_2  = 1'b0;
      w_in_action   = '0;
      w_res_score   = r_res_score;
      w_res_timeout = r_res_timeout;
      if (w_state_nxt == S_FEED1) begin
         w_in_valid_1 = 1'b1;
         w_in_color   = r_buf[w_fidx][2:0];
         if (w_fidx < 6'd4) begin
            w_in_pos    = r_buf[w_sidx][5:0];
            w_in_stripe = r_buf[w_sidx][6];
         end
      end
      if (w_state_nxt == S_FEED2) begin
         w_in_valid_2 = 1'b1;
         w_in_pos     = r_buf[w_aidx][5:0];
         w_in_action  = r_buf[w_aidx][7:6];
      end
      if (w_cc_hit) begin
         w_res_score   = cc_out_score;
         w_res_timeout = 1'b0;
      end else if (w_to_hit) begin
         w_res_score   = '0;
         w_res_timeout = 1'b1;
      end
   end

   // output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld_ready    <= 1'b0;
         r_in_valid_1  <= 1'b0;
         r_in_color    <= '0;
         r_in_pos      <= '0;
         r_in_stripe   <= 1'b0;
         r_in_valid_2  <= 1'b0;
         r_in_action   <= '0;
         r_res_valid   <= 1'b0;
         r_res_score   <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         r_ld_ready    <= w_ld_ready;
         r_in_valid_1  <= w_in_valid_1;
         r_in_color    <= w_in_color;
         r_in_pos      <= w_in_pos;
         r_in_stripe   <= w_in_stripe;
         r_in_valid_2  <= w_in_valid_2;
         r_in_action   <= w_in_action;
         r_res_valid   <= w_res_valid;
         r_res_score   <= w_res_score;
         r_res_timeout <= w_res_timeout;
      end
   end

   // frame buffer; raw words are stored and decoded on replay
   always_ff @(posedge clk) begin
      if (!rst && w_ld_acc) begin
         r_buf[r_cnt[5:0]] <= ld_data;
      end
   end

   assign ld_ready        = r_ld_ready;
   assign in_valid_1      = r_in_valid_1;
   assign in_color        = r_in_color;
   assign in_starting_pos = r_in_pos;
   assign in_stripe       = r_in_stripe;
   assign in_valid_2      = r_in_valid_2;
   assign in_action       = r_in_action;
   assign res_valid       = r_res_valid;
   assign res_score       = r_res_score;
   assign res_timeout     = r_res_timeout;

`ifdef CC_FEED_CHECK_EN
   logic r_cc_v_q;
   logic r_err;

   // sticky checker for stray/repeated pulses, zero scores and timeouts
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cc_v_q <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_cc_v_q <= cc_out_valid;
         if ((cc_out_valid && (r_state != S_WAIT))
             || (cc_out_valid && r_cc_v_q)
             || (w_cc_hit && (cc_out_score == 7'd0))
             || w_to_hit) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err_proto = r_err;
`else
   assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_cc_frame_driver.sv
// tb_cc_frame_driver: randomized frames checked against a frame-level model.
// Covers nominal, backpressure, timeout, tie, stall, stray pulse, reset.
module tb_cc_frame_driver;

   localparam int GAP = 2;
   localparam int TO  = 500;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld_valid = 1'b0;
   logic       ld_ready;
   logic [7:0] ld_data = '0;
   logic       in_valid_1;
   logic [2:0] in_color;
   logic [5:0] in_starting_pos;
   logic       in_stripe;
   logic       in_valid_2;
   logic [1:0] in_action;
   logic       cc_out_valid = 1'b0;
   logic [6:0] cc_out_score = '0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [6:0] res_score;
   logic       res_timeout;
   logic       err_proto;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic chk_en;
   logic exp_err;

   cc_frame_driver #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .in_valid_1(in_valid_1), .in_color(in_color),
      .in_starting_pos(in_starting_pos), .in_stripe(in_stripe),
      .in_valid_2(in_valid_2), .in_action(in_action),
      .cc_out_valid(cc_out_valid), .cc_out_score(cc_out_score),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_score(res_score), .res_timeout(res_timeout),
      .err_proto(err_proto)
   );

   always #5 clk = ~clk;

   wire [13:0] w_cc = {in_valid_1, in_color, in_starting_pos,
                       in_stripe, in_valid_2, in_action};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] cc_word(
      input logic v1, input logic [2:0] col, input logic [5:0] pos,
      input logic st, input logic v2, input logic [1:0] act);
      return {v1, col, pos, st, v2, act};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk("rst_cc", w_cc, 0);
      chk("rst_ldrdy", ld_ready, 0);
      chk("rst_res", {res_valid, res_score, res_timeout}, 0);
      chk("rst_err", err_proto, 0);
      rst = 1'b0;
      exp_err = 1'b0;
      tick();
      chk("rst_ldrdy1", ld_ready, 1);
      chk("rst_cc1", w_cc, 0);
   endtask

   // bp: random ld_valid; resp_at: WAIT cycle of CC pulse (-1 = never)
   // abort_at: FEED2 cycle that gets reset (-1 = none); stray: pulse in GAP
   task automatic run_frame(input int bp, input int resp_at,
                            input logic [6:0] score, input int stall,
                            input int abort_at, input int stray);
      logic [7:0]  words [50];
      logic [13:0] q [$];
      logic        acc;
      logic        tmo;
      int          k, budget, n, lat;
      for (int i = 0; i < 50; i++) words[i] = 8'($urandom);
      k = 0;
      budget = 0;
      while (k < 50 && budget < 2000) begin
         ld_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         ld_data  = ld_valid ? words[k] : 8'($urandom);
         acc = ld_valid && ld_ready;
         tick();
         if (acc) k++;
         budget++;
      end
      ld_valid = 1'b0;
      ld_data  = '0;
      chk("load_cnt", k, 50);
      chk("feed_ldrdy", ld_ready, 0);
      q = {};
      for (int i = 0; i < 36; i++) begin
         if (i < 4)
            q.push_back(cc_word(1'b1, words[i][2:0], words[36+i][5:0],
                                words[36+i][6], 1'b0, 2'd0));
         else
            q.push_back(cc_word(1'b1, words[i][2:0], 6'd0,
                                1'b0, 1'b0, 2'd0));
      end
      for (int i = 0; i < GAP; i++) q.push_back(14'd0);
      for (int j = 0; j < 10; j++)
         q.push_back(cc_word(1'b0, 3'd0, words[40+j][5:0],
                             1'b0, 1'b1, words[40+j][7:6]));
      q.push_back(14'd0);
      for (int idx = 0; idx < q.size(); idx++) begin
         if (abort_at >= 0 && idx == 36 + GAP + abort_at) begin
            do_reset();
            return;
         end
         chk($sformatf("stream%0d", idx), w_cc, q[idx]);
         if (idx == q.size() - 1) break;
         cc_out_valid = (stray != 0) && (idx == 36);
         cc_out_score = cc_out_valid ? 7'd99 : 7'd0;
         tick();
         cc_out_valid = 1'b0;
      end
      if (stray != 0) exp_err = exp_err | chk_en;
      n = 0;
      while (!res_valid && n < TO + 20) begin
         cc_out_valid = (n == resp_at);
         cc_out_score = cc_out_valid ? score : 7'($urandom);
         tick();
         cc_out_valid = 1'b0;
         n++;
      end
      tmo = (resp_at < 0) || (resp_at > TO - 1);
      lat = tmo ? TO : resp_at + 1;
      if (chk_en && (tmo || score == 7'd0)) exp_err = 1'b1;
      chk("wait_lat", n, lat);
      chk("res_valid", res_valid, 1);
      chk("res_score", res_score, tmo ? 7'd0 : score);
      chk("res_tmo", res_timeout, tmo);
      chk("err", err_proto, exp_err);
      for (int s = 0; s < stall; s++) begin
         chk("stall", {res_valid, res_score, res_timeout, ld_ready},
             {1'b1, (tmo ? 7'd0 : score), tmo, 1'b0});
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("next_ldrdy", {ld_ready, res_valid}, 2'b10);
   endtask

   initial begin
`ifdef CC_FEED_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      exp_err = 1'b0;
      do_reset();
      run_frame(0, 19, 7'd42, 2, -1, 0);
      run_frame(1, $urandom_range(0, 60), 7'($urandom_range(1, 127)),
                30, -1, 0);
      run_frame(0, -1, 7'd0, 3, -1, 0);
      run_frame(1, TO - 1, 7'd9, 1, -1, 0);
      run_frame(1, 5, 7'd11, 0, 3, 0);
      chk("abort_err", err_proto, 0);
      run_frame(1, $urandom_range(0, 40), 7'($urandom_range(1, 127)),
                $urandom_range(0, 8), -1, 0);
      for (int f = 0; f < 3; f++)
         run_frame(1, $urandom_range(0, 80), 7'($urandom_range(1, 127)),
                   $urandom_range(0, 8), -1, 0);
      run_frame(0, 3, 7'd77, 2, -1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
